conv1d_obi_rd_streamer: RTL and testbench
=========================================

CONV1D_OBI_RD_STREAMER -- requirements
Module: conv1d_obi_rd_streamer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, OBI address width.
REQ-002 SHALL have parameter DATA_W, default 32, OBI data width (multiple of 8).
REQ-003 SHALL have parameter LEN_W, default 16, burst length counter width.
REQ-004 SHALL have parameter MAX_OUTST, default 4, max granted-but-unanswered reads (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, response buffer depth (>=MAX_OUTST, power of 2).
REQ-006 SHALL have port clk_i  in  1  clock; one clock, all logic rising-edge.
REQ-007 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: command handshake.
REQ-009 SHALL have ports cmd_addr_i in ADDR_W (base byte address), cmd_len_i in LEN_W (word count), cmd_stride_i in ADDR_W (byte stride).
REQ-010 SHALL have OBI manager ports obi_req_o out 1, obi_we_o out 1, obi_be_o out DATA_W/8, obi_addr_o out ADDR_W, obi_wdata_o out DATA_W, obi_gnt_i in 1, obi_rvalid_i in 1, obi_rdata_i in DATA_W.
REQ-011 SHALL have stream ports dout_valid_o out 1, dout_ready_i in 1, dout_data_o out DATA_W, dout_last_o out 1.
REQ-012 SHALL have status ports busy_o out 1 (FSM not IDLE), done_o out 1 (single-cycle completion pulse).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-014 SHALL assert cmd_ready_o only in IDLE; command accepted on cmd_valid_i & cmd_ready_o, capturing addr, len, stride.
REQ-015 SHALL, on accepted command with len==0, stay in IDLE and pulse done_o the following cycle, issuing no OBI request.
REQ-016 SHALL, on accepted command with len>0, enter ISSUE next cycle.
REQ-017 SHALL drive obi_we_o=0, obi_be_o all ones, obi_wdata_o=0 at all times.
REQ-018 SHALL issue request k (k=0..len-1) at address base + k*stride, modulo 2^ADDR_W (wrap-around, no error).
REQ-019 SHALL raise obi_req_o in ISSUE only when issued<len, outst<MAX_OUTST and outst+fifo_count<FIFO_DEPTH.
REQ-020 SHALL hold obi_req_o high and obi_addr_o stable from assertion until the cycle obi_gnt_i=1 (OBI rule; the credit condition cannot become false while waiting).
REQ-021 SHALL allow back-to-back requests: new address in the cycle after a grant, zero bubble, if credit permits.
REQ-022 SHALL increment outst on grant, decrement on obi_rvalid_i; both in one cycle leaves outst unchanged.
REQ-023 SHALL push obi_rdata_i into the FIFO on every obi_rvalid_i with outst>0; rvalid with outst==0 SHALL be ignored.
REQ-024 SHALL move to DRAIN the cycle after the grant of request len-1.
REQ-025 SHALL present FIFO head on dout_*; transfer on dout_valid_o & dout_ready_i; FIFO push and pop same cycle keeps count.
REQ-026 SHALL assert dout_last_o with the word of index len-1 only.
REQ-027 SHALL, in DRAIN, return to IDLE and pulse done_o in the cycle after the last-word transfer.
REQ-028 SHALL have response-to-dout_valid_o latency of one cycle (registered FIFO write, fall-through read not required).
REQ-029 SHALL never overflow the FIFO; credit rule guarantees space for every outstanding response.

Reset
REQ-030 SHALL, on rst_i, go to IDLE, clear outst, issued and FIFO pointers; outputs next cycle: cmd_ready_o=1, obi_req_o=0, obi_addr_o=0, dout_valid_o=0, dout_last_o=0, busy_o=0, done_o=0.
REQ-031 SHALL, on rst_i mid-burst, abandon the burst; late rvalids afterwards fall under REQ-023 and are dropped.

Structure
REQ-032 SHALL place FSM state enum and default parameter localparams in the shared conv1d_obi_pkg alongside obi_req_t/obi_resp_t.
REQ-033 SHALL instantiate one sub-module conv1d_obi_fifo (synchronous FIFO, parameters DATA_W+1, FIFO_DEPTH, count output).

Verification
REQ-034 SHALL cover: base 0x1000, len 4, stride 4, gnt always 1, rvalid 1 cycle after gnt, ready 1 -> addrs 0x1000,0x1004,0x1008,0x100C on consecutive cycles, 4 words out, last on 4th, done pulse once.
REQ-035 SHALL cover: len 10, dout_ready_i=0 throughout -> exactly 8 grants, obi_req_o low afterwards, resumes after ready=1; all 10 words in order.
REQ-036 SHALL cover: memory delays rvalid 20 cycles, MAX_OUTST=4 -> outst peaks at 4, never 5.
REQ-037 SHALL cover: gnt withheld 5 cycles on req 2 -> obi_addr_o constant over those cycles, req stays high.
REQ-038 SHALL cover: base 0xFFFF_FFF8, stride 8, len 3 -> addrs 0xFFFF_FFF8, 0x0, 0x8; len 0 -> done next cycle, no request.
REQ-039 SHALL cover: rst_i at 3rd grant of len-8 burst -> next cycle IDLE, obi_req_o=0, dout_valid_o=0; following len-2 burst completes correctly.

Source files
------------

// File: rtl/conv1d_obi_pkg.sv
// Shared types and default sizing for the conv1d OBI read streamer.
package conv1d_obi_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 16;
    localparam int DEF_MAX_OUTST  = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // OBI manager-side request bundle at default widths
    typedef struct packed {
        logic                      req;
        logic                      we;
        logic [DEF_DATA_W/8-1:0]   be;
        logic [DEF_ADDR_W-1:0]     addr;
        logic [DEF_DATA_W-1:0]     wdata;
    } obi_req_t;

    // OBI subordinate-side response bundle at default widths
    typedef struct packed {
        logic                      gnt;
        logic                      rvalid;
        logic [DEF_DATA_W-1:0]     rdata;
    } obi_resp_t;

endpackage

// File: rtl/conv1d_obi_fifo.sv
// Synchronous FIFO with registered write and combinational head read.
// A pushed word is visible at the head one cycle after the push.
module conv1d_obi_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage array; not reset, contents only meaningful below count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv1d_obi_rd_streamer.sv
// Strided OBI read burst engine: issues len reads at base + k*stride and
// streams the responses out in order, tagging the final word.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready_o high
// ST_ISSUE | issuing reads while credit allows
// ST_DRAIN | all reads granted; waiting for the last word to leave
module conv1d_obi_rd_streamer
    import conv1d_obi_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int MAX_OUTST  = DEF_MAX_OUTST,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [LEN_W-1:0]    cmd_len_i,
    input  logic [ADDR_W-1:0]   cmd_stride_i,
    output logic                obi_req_o,
    output logic                obi_we_o,
    output logic [DATA_W/8-1:0] obi_be_o,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_gnt_i,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i,
    output logic                dout_valid_o,
    input  logic                dout_ready_i,
    output logic [DATA_W-1:0]   dout_data_o,
    output logic                dout_last_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  push_idx;
    logic [OUT_W-1:0]  outst;
    logic              done;

    logic              grant;
    logic              resp;
    logic              credit_ok;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_wdata;
    logic [DATA_W:0]   fifo_rdata;
    logic              last_xfer;

    // Read-only manager: write channel tied off
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign obi_wdata_o = '0;

    // Outstanding reads plus buffered words must never exceed the buffer,
    // so every granted read already owns a FIFO slot. While a request
    // waits for grant this sum can only shrink, so req never drops early.
    assign credit_ok = (outst < OUT_W'(MAX_OUTST)) &&
                       ((32'(outst) + 32'(fifo_count)) < 32'(FIFO_DEPTH));

    assign obi_req_o  = (state == ST_ISSUE) && (issued < len) && credit_ok;
    assign obi_addr_o = cur_addr;
    assign grant      = obi_req_o && obi_gnt_i;
    assign resp       = obi_rvalid_i && (outst != '0);

    assign fifo_wdata = {(push_idx == len - LEN_W'(1)), obi_rdata_i};
    assign fifo_pop   = dout_valid_o && dout_ready_i;

    assign dout_valid_o = !fifo_empty;
    assign dout_data_o  = fifo_rdata[DATA_W-1:0];
    assign dout_last_o  = !fifo_empty && fifo_rdata[DATA_W];
    assign last_xfer    = fifo_pop && fifo_rdata[DATA_W];

    assign cmd_ready_o = (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = done;

    // Burst sequencing, address generation and outstanding-read tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            len      <= '0;
            stride   <= '0;
            cur_addr <= '0;
            issued   <= '0;
            push_idx <= '0;
            outst    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        len      <= cmd_len_i;
                        stride   <= cmd_stride_i;
                        cur_addr <= cmd_addr_i;
                        issued   <= '0;
                        push_idx <= '0;
                        if (cmd_len_i == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (grant) begin
                        cur_addr <= cur_addr + stride;
                        issued   <= issued + LEN_W'(1);
                        if (issued == len - LEN_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_xfer) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (grant && !resp) begin
                outst <= outst + OUT_W'(1);
            end else if (!grant && resp) begin
                outst <= outst - OUT_W'(1);
            end

            if (resp) begin
                push_idx <= push_idx + LEN_W'(1);
            end
        end
    end

    conv1d_obi_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (resp),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_conv1d_obi_rd_streamer.sv
// Bench for conv1d_obi_rd_streamer: OBI memory model, scoreboard of
// expected addresses and output words, directed burst scenarios.
module tb_conv1d_obi_rd_streamer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int MAXO   = 4;
    localparam int DEPTH  = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i = '0;
    logic [LEN_W-1:0]  cmd_len_i = '0;
    logic [ADDR_W-1:0] cmd_stride_i = '0;
    logic              obi_req_o;
    logic              obi_we_o;
    logic [3:0]        obi_be_o;
    logic [ADDR_W-1:0] obi_addr_o;
    logic [DATA_W-1:0] obi_wdata_o;
    logic              obi_gnt_i = 1'b0;
    logic              obi_rvalid_i = 1'b0;
    logic [DATA_W-1:0] obi_rdata_i = '0;
    logic              dout_valid_o;
    logic              dout_ready_i = 1'b0;
    logic [DATA_W-1:0] dout_data_o;
    logic              dout_last_o;
    logic              busy_o;
    logic              done_o;

    conv1d_obi_rd_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .MAX_OUTST(MAXO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_stride_i(cmd_stride_i),
        .obi_req_o(obi_req_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_addr_o(obi_addr_o), .obi_wdata_o(obi_wdata_o),
        .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
        .dout_data_o(dout_data_o), .dout_last_o(dout_last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // scoreboard and memory model state
    logic [31:0] exp_addr_q[$];
    logic [32:0] exp_dout_q[$];
    int          resp_due_q[$];
    logic [31:0] resp_data_q[$];

    int          cyc = 0;
    int          rv_delay = 1;
    logic        ready_en = 1'b0;
    logic        rst_cmd = 1'b1;
    logic        rst_pulse = 1'b0;
    int          rst_at = -1;
    int          grant_total = 0;
    int          done_total = 0;
    int          words_out = 0;
    int          model_outst = 0;
    int          peak = 0;
    int          first_gnt_cyc = -1;
    int          last_gnt_cyc = -1;
    logic        stall_armed = 1'b0;
    int          stall_at = -1;
    int          stall_cnt = 0;
    logic [31:0] stall_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    // One cycle: drive memory/sink inputs at the falling edge and score
    // whatever the DUT will commit at the next rising edge.
    task automatic tick();
        logic        gnt;
        logic [31:0] a;
        logic [32:0] e;
        @(negedge clk_i);
        cyc++;
        rst_pulse = 1'b0;
        gnt = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i = '0;
        if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
            obi_rvalid_i = 1'b1;
            obi_rdata_i = resp_data_q.pop_front();
            void'(resp_due_q.pop_front());
            if (model_outst > 0) model_outst--;
        end
        if (stall_cnt > 0) begin
            chk("stall_req", obi_req_o, 1);
            chk("stall_addr", obi_addr_o, stall_addr);
            stall_cnt--;
        end else if (stall_armed && obi_req_o && (grant_total + 1 == stall_at)) begin
            stall_armed = 1'b0;
            stall_cnt = 4;
            stall_addr = obi_addr_o;
        end else begin
            gnt = obi_req_o;
        end
        obi_gnt_i = gnt;
        dout_ready_i = ready_en;
        if (gnt) begin
            grant_total++;
            if (grant_total == rst_at) rst_pulse = 1'b1;
        end
        rst_i = rst_cmd | rst_pulse;
        if (rst_i) begin
            exp_addr_q.delete();
            exp_dout_q.delete();
            model_outst = 0;
        end else begin
            if (gnt) begin
                if (exp_addr_q.size() == 0) begin
                    chk("grant_unexpected", exp_addr_q.size(), 1);
                end else begin
                    a = exp_addr_q.pop_front();
                    chk("obi_addr", obi_addr_o, a);
                end
                resp_due_q.push_back(cyc + rv_delay);
                resp_data_q.push_back(mem_data(obi_addr_o));
                model_outst++;
                if (model_outst > peak) peak = model_outst;
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
                last_gnt_cyc = cyc;
            end
            if (dout_valid_o && dout_ready_i) begin
                if (exp_dout_q.size() == 0) begin
                    chk("dout_unexpected", exp_dout_q.size(), 1);
                end else begin
                    e = exp_dout_q.pop_front();
                    chk("dout_data", dout_data_o, e[31:0]);
                    chk("dout_last", dout_last_o, e[32]);
                end
                words_out++;
            end
        end
        if (done_o) done_total++;
    endtask

    task automatic start_burst(input logic [31:0] base, input int len, input logic [31:0] stride);
        logic [31:0] a;
        for (int k = 0; k < len; k++) begin
            a = base + 32'(k) * stride;
            exp_addr_q.push_back(a);
            exp_dout_q.push_back({(k == len - 1), mem_data(a)});
        end
        words_out = 0;
        first_gnt_cyc = -1;
        chk("cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_addr_i = base;
        cmd_len_i = LEN_W'(len);
        cmd_stride_i = stride;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int start, input int budget);
        int n = 0;
        while (done_total == start && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", (done_total > start), 1);
    endtask

    task automatic settle(input int start, input int words);
        repeat (5) tick();
        chk("done_once", done_total - start, 1);
        chk("words_out", words_out, words);
        chk("sb_empty", exp_dout_q.size() + exp_addr_q.size(), 0);
        chk("idle_busy", busy_o, 0);
    endtask

    initial begin
        int d0;
        int g0;
        int n;

        repeat (3) tick();
        rst_cmd = 1'b0;
        tick();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_req", obi_req_o, 0);
        chk("rst_addr", obi_addr_o, 0);
        chk("rst_dout_valid", dout_valid_o, 0);
        chk("rst_dout_last", dout_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("tie_we", obi_we_o, 0);
        chk("tie_be", obi_be_o, 4'hF);
        chk("tie_wdata", obi_wdata_o, 0);

        // basic back-to-back burst
        rv_delay = 1; ready_en = 1'b1;
        d0 = done_total;
        start_burst(32'h0000_1000, 4, 32'd4);
        wait_done(d0, 100);
        chk("t1_gnt_span", last_gnt_cyc - first_gnt_cyc, 3);
        settle(d0, 4);

        // sink stalled: credit limits grants to the buffer depth
        ready_en = 1'b0;
        d0 = done_total;
        g0 = grant_total;
        start_burst(32'h0000_2000, 10, 32'd4);
        repeat (60) tick();
        chk("t2_grants", grant_total - g0, 8);
        chk("t2_req_low", obi_req_o, 0);
        chk("t2_dout_valid", dout_valid_o, 1);
        ready_en = 1'b1;
        wait_done(d0, 200);
        settle(d0, 10);

        // slow memory: outstanding limit
        rv_delay = 20;
        peak = 0;
        d0 = done_total;
        start_burst(32'h0000_3000, 8, 32'd16);
        wait_done(d0, 400);
        chk("t3_peak_outst", peak, MAXO);
        settle(d0, 8);

        // grant withheld on the third request
        rv_delay = 1;
        stall_armed = 1'b1;
        stall_at = grant_total + 3;
        d0 = done_total;
        start_burst(32'h0000_4000, 6, 32'd4);
        wait_done(d0, 200);
        chk("t4_stall_seen", stall_armed, 0);
        settle(d0, 6);

        // address wrap-around
        d0 = done_total;
        start_burst(32'hFFFF_FFF8, 3, 32'd8);
        wait_done(d0, 100);
        settle(d0, 3);

        // zero-length command
        d0 = done_total;
        g0 = grant_total;
        start_burst(32'h0000_5000, 0, 32'd4);
        chk("len0_done", done_o, 1);
        chk("len0_req", obi_req_o, 0);
        repeat (5) tick();
        chk("len0_grants", grant_total - g0, 0);
        chk("len0_done_once", done_total - d0, 1);

        // reset on the third grant of a len-8 burst, late responses dropped
        rv_delay = 3;
        rst_at = grant_total + 3;
        start_burst(32'h0000_6000, 8, 32'd4);
        n = 0;
        while (rst_i == 1'b0 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_rst_hit", rst_i, 1);
        tick();
        chk("t6_cmd_ready", cmd_ready_o, 1);
        chk("t6_req", obi_req_o, 0);
        chk("t6_dout_valid", dout_valid_o, 0);
        chk("t6_busy", busy_o, 0);
        repeat (10) tick();
        chk("t6_late_dropped", dout_valid_o, 0);
        rst_at = -1;
        rv_delay = 1;
        d0 = done_total;
        start_burst(32'h0000_7000, 2, 32'd4);
        wait_done(d0, 100);
        settle(d0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
